// File: rtl/unified_mem_arbiter.sv
// Arbiter for the single unified instruction/data memory port shared by IF and MEM.
// Grants in IDLE, holds the access for MEM_LAT cycles, returns registered read data.
module unified_mem_arbiter #(
  parameter int unsigned MEM_LAT      = 2,
  parameter int unsigned MAX_DM_BURST = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic        dm_gnt_o,
  output logic        dm_rvalid_o,
  output logic [31:0] dm_rdata_o,
  output logic        mem_sel_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        pipe_stall_o
);

  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned STK_W = $clog2(MAX_DM_BURST + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_DM_BURST);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic [31:0]      dm_rdata_q, dm_rdata_d;
  logic             if_rvalid_q, if_rvalid_d;
  logic             dm_rvalid_q, dm_rvalid_d;
  logic [STK_W-1:0] streak_q, streak_d;
  logic             mem_en_q, mem_en_d;
  logic             mem_sel_q, mem_sel_d;
  logic             mem_we_q, mem_we_d;
  logic             if_gnt, dm_gnt;

  // Next-state, arbitration and access sequencing
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    streak_d    = streak_q;
    if_gnt      = 1'b0;
    dm_gnt      = 1'b0;
    mem_en_d    = 1'b0;
    mem_sel_d   = 1'b0;
    mem_we_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Data has priority until it has starved IF for MAX_DM_BURST grants
        if (if_req_i && (!dm_req_i || (streak_q == STK_MAX))) begin
          if_gnt = 1'b1;
        end else if (dm_req_i) begin
          dm_gnt = 1'b1;
        end
        if (if_gnt || dm_gnt) begin
          state_d = S_BUSY;
          cnt_d   = CNT_LAST;
          owner_d = dm_gnt;
          we_d    = dm_gnt & dm_we_i;
          addr_d  = dm_gnt ? dm_addr_i : if_addr_i;
          if (dm_gnt) begin
            wdata_d = dm_wdata_i;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          if (owner_q) begin
            dm_rvalid_d = 1'b1;
            if (!we_q) begin
              dm_rdata_d = mem_rdata_i;
            end
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata_i;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!if_req_i || if_gnt) begin
      streak_d = '0;
    end else if (dm_gnt && (streak_q != STK_MAX)) begin
      streak_d = streak_q + 1'b1;
    end

    // Memory-side controls are registered from the next state
    mem_en_d  = (state_d == S_BUSY);
    mem_sel_d = (state_d == S_BUSY) & owner_d;
    mem_we_d  = (state_d == S_BUSY) && (cnt_d == '0) && we_d && owner_d;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      streak_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_sel_q   <= 1'b0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      streak_q    <= streak_d;
      mem_en_q    <= mem_en_d;
      mem_sel_q   <= mem_sel_d;
      mem_we_q    <= mem_we_d;
    end
  end

  // Grants and stall are same-cycle; forced low while reset is asserted
  assign if_gnt_o     = rst_i & if_gnt;
  assign dm_gnt_o     = rst_i & dm_gnt;
  assign pipe_stall_o = rst_i & ((state_q == S_BUSY) | (if_req_i & ~if_gnt) | (dm_req_i & ~dm_gnt));

  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rvalid_o = dm_rvalid_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign mem_sel_o   = mem_sel_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed table, corner sequences and random traffic
// against a time-based reference model; a second MEM_LAT=1 instance covers back-to-back fetches.
module tb_unified_mem_arbiter;

  localparam int LAT  = 2;
  localparam int MAXB = 4;

  logic        clk;
  logic        rst_i;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_sel, mem_en, mem_we, pipe_stall;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

  logic        b_if_req, b_dm_req, b_dm_we;
  logic [31:0] b_if_addr, b_dm_addr, b_dm_wdata, b_mem_rdata;
  logic        b_if_gnt, b_if_rvalid, b_dm_gnt, b_dm_rvalid, b_mem_sel, b_mem_en, b_mem_we, b_stall;
  logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata;

  unified_mem_arbiter #(.MEM_LAT(LAT), .MAX_DM_BURST(MAXB)) u_dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_gnt_o(dm_gnt), .dm_rvalid_o(dm_rvalid), .dm_rdata_o(dm_rdata),
    .mem_sel_o(mem_sel), .mem_en_o(mem_en), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .pipe_stall_o(pipe_stall)
  );

  unified_mem_arbiter #(.MEM_LAT(1), .MAX_DM_BURST(MAXB)) u_dut1 (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(b_if_req), .if_addr_i(b_if_addr), .if_gnt_o(b_if_gnt),
    .if_rvalid_o(b_if_rvalid), .if_rdata_o(b_if_rdata),
    .dm_req_i(b_dm_req), .dm_we_i(b_dm_we), .dm_addr_i(b_dm_addr), .dm_wdata_i(b_dm_wdata),
    .dm_gnt_o(b_dm_gnt), .dm_rvalid_o(b_dm_rvalid), .dm_rdata_o(b_dm_rdata),
    .mem_sel_o(b_mem_sel), .mem_en_o(b_mem_en), .mem_we_o(b_mem_we),
    .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata),
    .pipe_stall_o(b_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          ifr;
    logic [31:0] ifa;
    bit          dmr;
    bit          dmw;
    logic [31:0] dma;
    logic [31:0] dmd;
    logic [31:0] mrd;
    bit          e_ifg;
    bit          e_dmg;
    bit          e_en;
    bit          e_sel;
    bit          e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    bit          e_ifrv;
    logic [31:0] e_ifrd;
    bit          e_dmrv;
    logic [31:0] e_dmrd;
    bit          e_stall;
  } vec_t;

  vec_t tv [14];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: an access granted in cycle g occupies cycles g+1..g+LAT, completes in g+LAT+1
  int          g_cyc = -1000;
  bit          g_own, g_we;
  logic [31:0] m_addr, m_wdata, m_ifrd, m_dmrd;
  int          streak;
  bit          m_ig, m_dg;

  bit          if_pend, dm_pend;
  int          got [$];
  int          exp_seq [6] = '{1, 1, 1, 1, 0, 1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    g_cyc   = -1000;
    g_own   = 1'b0;
    g_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_ifrd  = '0;
    m_dmrd  = '0;
    streak  = 0;
  endtask

  task automatic check_main();
    bit en_e, fin_e, rv_e;
    m_ig = 1'b0;
    m_dg = 1'b0;
    if (!rst_i) begin
      chk("rst_ctrl", 32'({if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_en, mem_sel, mem_we, pipe_stall}), 32'h0);
      chk("rst_words", if_rdata | dm_rdata | mem_addr | mem_wdata, 32'h0);
      model_reset();
    end else begin
      en_e  = (cyc > g_cyc) && (cyc <= g_cyc + LAT);
      fin_e = (cyc == g_cyc + LAT);
      rv_e  = (cyc == g_cyc + LAT + 1);
      if (!en_e) begin
        m_ig = if_req && (!dm_req || streak == MAXB);
        m_dg = dm_req && !m_ig;
      end
      chk("if_gnt", 32'(if_gnt), 32'(m_ig));
      chk("dm_gnt", 32'(dm_gnt), 32'(m_dg));
      chk("mem_en", 32'(mem_en), 32'(en_e));
      chk("mem_sel", 32'(mem_sel), 32'(en_e & g_own));
      chk("mem_we", 32'(mem_we), 32'(fin_e & g_own & g_we));
      chk("mem_addr", mem_addr, m_addr);
      if (en_e && g_own) chk("mem_wdata", mem_wdata, m_wdata);
      chk("if_rvalid", 32'(if_rvalid), 32'(rv_e & !g_own));
      chk("dm_rvalid", 32'(dm_rvalid), 32'(rv_e & g_own));
      chk("if_rdata", if_rdata, m_ifrd);
      chk("dm_rdata", dm_rdata, m_dmrd);
      chk("pipe_stall", 32'(pipe_stall), 32'(en_e | (if_req & !m_ig) | (dm_req & !m_dg)));
      if (fin_e) begin
        if (!g_own) m_ifrd = mem_rdata;
        else if (!g_we) m_dmrd = mem_rdata;
      end
      if (m_ig || m_dg) begin
        g_cyc  = cyc;
        g_own  = m_dg;
        g_we   = m_dg & dm_we;
        m_addr = m_dg ? dm_addr : if_addr;
        if (m_dg) m_wdata = dm_wdata;
      end
      if (!if_req || m_ig) streak = 0;
      else if (m_dg && streak < MAXB) streak++;
    end
    cyc++;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    #2;
    check_main();
    advance();
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          ifr   ifa        dmr   dmw   dma          dmd           mrd            ifg   dmg   en    sel   we    addr         wd            ifrv  ifrd          dmrv  dmrd          stall
    tv[0]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,    32'h0,        32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0};
    tv[1]  = '{1'b0, 32'h40, 1'b0, 1'b0, 32'h0,    32'h0,        32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40,   32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b1};
    tv[2]  = '{1'b0, 32'h40, 1'b0, 1'b0, 32'h0,    32'h0,        32'h00500093,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40,   32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b1};
    tv[3]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,    32'h0,        32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40,   32'h0,        1'b1, 32'h00500093, 1'b0, 32'h0,        1'b0};
    tv[4]  = '{1'b1, 32'h44, 1'b1, 1'b0, 32'h1000, 32'h0,        32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40,   32'h0,        1'b0, 32'h00500093, 1'b0, 32'h0,        1'b1};
    tv[5]  = '{1'b1, 32'h44, 1'b0, 1'b0, 32'h0,    32'h0,        32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1000, 32'h0,        1'b0, 32'h00500093, 1'b0, 32'h0,        1'b1};
    tv[6]  = '{1'b1, 32'h44, 1'b0, 1'b0, 32'h0,    32'h0,        32'h12345678,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1000, 32'h0,        1'b0, 32'h00500093, 1'b0, 32'h0,        1'b1};
    tv[7]  = '{1'b1, 32'h44, 1'b0, 1'b0, 32'h0,    32'h0,        32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000, 32'h0,        1'b0, 32'h00500093, 1'b1, 32'h12345678, 1'b0};
    tv[8]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,    32'h0,        32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h44,   32'h0,        1'b0, 32'h00500093, 1'b0, 32'h12345678, 1'b1};
    tv[9]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,    32'h0,        32'h00A00113,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h44,   32'h0,        1'b0, 32'h00500093, 1'b0, 32'h12345678, 1'b1};
    tv[10] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h2004, 32'hDEADBEEF, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h44,   32'h0,        1'b1, 32'h00A00113, 1'b0, 32'h12345678, 1'b0};
    tv[11] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,    32'h0,        32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h2004, 32'hDEADBEEF, 1'b0, 32'h00A00113, 1'b0, 32'h12345678, 1'b1};
    tv[12] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,    32'h0,        32'hFFFFFFFF,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h2004, 32'hDEADBEEF, 1'b0, 32'h00A00113, 1'b0, 32'h12345678, 1'b1};
    tv[13] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,    32'h0,        32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2004, 32'hDEADBEEF, 1'b0, 32'h00A00113, 1'b1, 32'h12345678, 1'b0};

    rst_i = 1'b0;
    idle_inputs();
    b_if_req = 1'b0; b_if_addr = '0; b_dm_req = 1'b0; b_dm_we = 1'b0;
    b_dm_addr = '0; b_dm_wdata = '0; b_mem_rdata = '0;
    model_reset();
    advance();
    tick();
    tick();
    rst_i = 1'b1;

    // Directed table: single fetch, simultaneous load+fetch, store
    for (int r = 0; r < 14; r++) begin
      if_req = tv[r].ifr; if_addr = tv[r].ifa; dm_req = tv[r].dmr; dm_we = tv[r].dmw;
      dm_addr = tv[r].dma; dm_wdata = tv[r].dmd; mem_rdata = tv[r].mrd;
      #2;
      chk($sformatf("tv%0d_ctrl", r),
          32'({if_gnt, dm_gnt, mem_en, mem_sel, mem_we, if_rvalid, dm_rvalid, pipe_stall}),
          32'({tv[r].e_ifg, tv[r].e_dmg, tv[r].e_en, tv[r].e_sel, tv[r].e_we, tv[r].e_ifrv, tv[r].e_dmrv, tv[r].e_stall}));
      chk($sformatf("tv%0d_addr", r), mem_addr, tv[r].e_addr);
      chk($sformatf("tv%0d_wdata", r), mem_wdata, tv[r].e_wd);
      chk($sformatf("tv%0d_if_rdata", r), if_rdata, tv[r].e_ifrd);
      chk($sformatf("tv%0d_dm_rdata", r), dm_rdata, tv[r].e_dmrd);
      check_main();
      advance();
    end
    idle_inputs();

    // Starvation: both requests held continuously
    got.delete();
    for (int k = 0; k < 60 && got.size() < 6; k++) begin
      if_req = 1'b1; if_addr = 32'h80; dm_req = 1'b1; dm_we = 1'b0;
      dm_addr = 32'h1100; dm_wdata = '0; mem_rdata = 32'h5A5A0000 + 32'(k);
      #2;
      if (dm_gnt) got.push_back(1);
      if (if_gnt) got.push_back(0);
      check_main();
      advance();
    end
    chk("starve_grant_count", 32'(got.size()), 32'd6);
    for (int i = 0; i < got.size() && i < 6; i++)
      chk($sformatf("starve_grant%0d_is_data", i), 32'(got[i]), 32'(exp_seq[i]));
    idle_inputs();
    for (int k = 0; k < 4; k++) tick();

    // Reset in the final cycle of a store aborts it
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h3000; dm_wdata = 32'hCAFEF00D;
    #2;
    chk("rst_store_gnt", 32'(dm_gnt), 32'd1);
    check_main();
    advance();
    dm_req = 1'b0; dm_we = 1'b0; dm_wdata = '0;
    #2;
    chk("rst_store_busy", 32'({mem_en, mem_sel, mem_we}), 32'b110);
    check_main();
    advance();
    rst_i = 1'b0; if_req = 1'b1; if_addr = 32'h200;
    #2;
    chk("rst_abort_ctrl", 32'({if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_en, mem_sel, mem_we, pipe_stall}), 32'h0);
    chk("rst_abort_addr", mem_addr, 32'h0);
    chk("rst_abort_wdata", mem_wdata, 32'h0);
    check_main();
    advance();
    tick();
    rst_i = 1'b1;
    #2;
    chk("post_rst_if_gnt", 32'(if_gnt), 32'd1);
    chk("post_rst_no_dm_rvalid", 32'(dm_rvalid), 32'd0);
    check_main();
    advance();
    idle_inputs();
    for (int k = 0; k < 4; k++) tick();

    // MEM_LAT=1 instance: back-to-back fetches every other cycle
    for (int j = 0; j < 10; j++) begin
      bit even;
      even = (j % 2) == 0;
      b_if_req = 1'b1;
      b_if_addr = 32'h100 + 32'(4 * ((j + 1) / 2));
      b_mem_rdata = 32'hA0000000 + 32'(j);
      #2;
      chk("b_if_gnt", 32'(b_if_gnt), 32'(even));
      chk("b_stall", 32'(b_stall), 32'(!even));
      chk("b_mem_en", 32'(b_mem_en), 32'(!even));
      chk("b_if_rvalid", 32'(b_if_rvalid), 32'(even && j > 0));
      if (even && j > 0) chk("b_if_rdata", b_if_rdata, 32'hA0000000 + 32'(j - 1));
      if (!even) chk("b_mem_addr", b_mem_addr, 32'h100 + 32'(2 * (j - 1)));
      chk("b_data_side", 32'({b_dm_gnt, b_dm_rvalid, b_mem_sel, b_mem_we}), 32'h0);
      chk("b_data_words", b_dm_rdata | b_mem_wdata, 32'h0);
      check_main();
      advance();
    end
    b_if_req = 1'b0;

    // Random traffic obeying hold-until-grant
    if_pend = 1'b0;
    dm_pend = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!if_pend && $urandom_range(99) < 50) begin
        if_pend = 1'b1;
        if_addr = $urandom & 32'hFFFFFFFC;
      end
      if (!dm_pend && $urandom_range(99) < 60) begin
        dm_pend  = 1'b1;
        dm_we    = 1'($urandom_range(1));
        dm_addr  = $urandom;
        dm_wdata = $urandom;
      end
      if_req = if_pend;
      dm_req = dm_pend;
      mem_rdata = $urandom;
      #2;
      check_main();
      if (m_ig) if_pend = 1'b0;
      if (m_dg) dm_pend = 1'b0;
      advance();
    end
    idle_inputs();
    for (int k = 0; k < 4; k++) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Arbitrates a single unified instruction/data memory port between the IF stage and the MEM stage of the pipelined CPU.
- Drives the select of the 32-bit 2-to-1 address/data mux in front of the memory: 0 = IF, 1 = data.
- Sequences each multi-cycle access and returns registered read data with a valid pulse.
- Generates the pipeline stall.

Parameters:
MEM_LAT, 2, memory access length in cycles (>=1); address/control held stable for the whole access.
MAX_DM_BURST, 4, max consecutive data grants while IF waits before IF is forced through.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
if_req_i  in  1  fetch request; held until if_gnt_o
if_addr_i  in  32  fetch address
if_gnt_o  out  1  fetch accepted this cycle
if_rvalid_o  out  1  one-cycle pulse, if_rdata_o valid
if_rdata_o  out  32  fetched instruction, registered
dm_req_i  in  1  data request; held until dm_gnt_o
dm_we_i  in  1  1 = store, 0 = load
dm_addr_i  in  32  data address
dm_wdata_i  in  32  store data
dm_gnt_o  out  1  data request accepted this cycle
dm_rvalid_o  out  1  one-cycle pulse on completion of load or store
dm_rdata_o  out  32  load data, registered
mem_sel_o  out  1  mux select: 0 = IF, 1 = data
mem_en_o  out  1  access in progress
mem_we_o  out  1  write strobe, final access cycle only
mem_addr_o  out  32  latched access address
mem_wdata_o  out  32  latched store data
mem_rdata_i  in  32  memory read data, valid in final access cycle
pipe_stall_o  out  1  pipeline freeze

Behaviour:
- Reset (rst_i low, async):
  - State IDLE; cnt=0; dm_streak=0; owner=0.
  - All outputs 0, including latched addr/wdata/rdata regs.
  - Reset during an access aborts it: no rvalid, mem_we_o drops immediately.
- States: IDLE, BUSY.
- IDLE:
  - mem_en_o=0, mem_sel_o=0.
  - Grant is combinational on the requests, same cycle:
    - only if_req_i: IF wins.
    - only dm_req_i: data wins.
    - both: data wins unless dm_streak==MAX_DM_BURST, then IF wins.
  - Exactly one gnt high. At the edge: latch addr, we, wdata; owner := winner; cnt := MEM_LAT-1; -> BUSY.
- BUSY:
  - mem_en_o=1; mem_sel_o=owner; mem_addr_o/mem_wdata_o from latches, stable all cycles.
  - No grants in BUSY.
  - cnt decrements each cycle.
  - Final cycle (cnt==0):
    - mem_we_o = latched we & owner.
    - mem_rdata_i captured into the owner's rdata reg at the edge (store: dm_rdata_o unchanged).
    - -> IDLE.
- Completion:
  - Owner's rvalid pulses exactly one cycle, in the cycle after the final BUSY cycle.
  - A new grant may occur in that same cycle.
  - Access occupancy is 1+MEM_LAT cycles; request-to-rvalid latency is MEM_LAT+1 cycles after the grant cycle.
- dm_streak:
  - +1 (saturating at MAX_DM_BURST) on a data grant while if_req_i=1.
  - Cleared on an IF grant or any cycle with if_req_i=0.
- pipe_stall_o = (state==BUSY) | (if_req_i & ~if_gnt_o) | (dm_req_i & ~dm_gnt_o).
- rdata regs hold their value until the next completion for that owner.

Test Plan:
1. Reset: rst_i=0 mid-BUSY with store pending -> all outputs 0 at once, no mem_we_o, no dm_rvalid_o; after release state IDLE.
2. Single fetch, MEM_LAT=2: if_req_i, if_addr_i=0x40 in cycle 0 -> if_gnt_o in cycle 0; mem_en_o=1, mem_sel_o=0, mem_addr_o=0x40 in cycles 1-2; mem_rdata_i=0x00500093 in cycle 2 -> if_rvalid_o=1, if_rdata_o=0x00500093 in cycle 3.
3. Simultaneous requests: if_req_i and dm_req_i both high (load 0x1000) -> dm_gnt_o first, mem_sel_o=1; IF granted in the cycle dm_rvalid_o pulses.
4. Store: dm_we_i=1, addr 0x2004, wdata 0xDEADBEEF -> mem_we_o high only in final BUSY cycle; mem_wdata_o stable throughout; dm_rvalid_o pulses; dm_rdata_o unchanged.
5. Starvation: if_req_i held, dm_req_i held continuously -> exactly 4 data grants, then if_gnt_o, then data resumes.
6. MEM_LAT=1 back-to-back fetches -> grants every 2 cycles; pipe_stall_o low only in grant cycles.
